// File: rtl/apb_slave_regfile.sv
// APB3 completer register file with fixed wait states and error response.
// Target device behind the AHB-to-APB bridge.
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-3:0] NREG = (ADDR_WIDTH-2)'(NUM_REGS);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [IW-1:0]         r_idx;
    logic                  r_write;
    logic                  r_err;
    logic [3:0]            r_wcnt;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [ADDR_WIDTH-3:0] w_idx;
    logic                  w_err;
    logic                  w_setup;
    logic                  w_access;
    logic                  w_ready;
    logic                  w_commit;

    assign w_idx    = PADDR[ADDR_WIDTH-1:2];
    assign w_err    = (PADDR[1:0] != 2'b00) || (w_idx >= NREG);
    assign w_setup  = PSEL && !PENABLE;
    assign w_access = PSEL && PENABLE;
    assign w_ready  = (r_state == S_ACCESS) && (r_wcnt == WS);
    // An aborted cycle (PSEL low) never commits, even if the count is reached.
    assign w_commit = w_ready && w_access && r_write && !r_err;

    // State register; reset wins over a pending completion.
    always_ff @(posedge PCLK) begin
        if (PRESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state: setup enters ACCESS, completion or abort returns to IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_setup) w_next = S_ACCESS;
            S_ACCESS: if (!PSEL || w_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Wait counter: cleared while idle, advances on each held access cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET)
            r_wcnt <= '0;
        else if (r_state == S_IDLE)
            r_wcnt <= '0;
        else if (w_access && (r_wcnt != WS))
            r_wcnt <= r_wcnt + 4'd1;
    end

    // Capture index, direction and error status in the setup phase.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else if ((r_state == S_IDLE) && w_setup) begin
            r_idx   <= PADDR[IW+1:2];
            r_write <= PWRITE;
            r_err   <= w_err;
        end
    end

    // Register array; write data is sampled live on the completing cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            r_regs[r_idx] <= PWDATA;
        end
    end

    assign PREADY  = w_ready;
    assign PSLVERR = w_ready && r_err;
    assign PRDATA  = (w_ready && !r_write && !r_err) ? r_regs[r_idx] : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized bench for apb_slave_regfile against an array reference model.
// Two instances: zero wait states and three wait states.
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        preset  [2];
    logic        psel    [2];
    logic        penable [2];
    logic [31:0] paddr   [2];
    logic        pwrite  [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [2][16];
    int          ws_of [2];

    always #5 clk = ~clk;

    apb_slave_regfile #(.WAIT_STATES(0)) u_dut0 (
        .PCLK(clk), .PRESET(preset[0]), .PSEL(psel[0]),
        .PENABLE(penable[0]), .PADDR(paddr[0]), .PWRITE(pwrite[0]),
        .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0])
    );

    apb_slave_regfile #(.WAIT_STATES(3)) u_dut3 (
        .PCLK(clk), .PRESET(preset[1]), .PSEL(psel[1]),
        .PENABLE(penable[1]), .PADDR(paddr[1]), .PWRITE(pwrite[1]),
        .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model(input int d);
        for (int i = 0; i < 16; i++) model[d][i] = '0;
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
    endtask

    task automatic do_reset(input int d);
        @(posedge clk); #1;
        preset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        preset[d] = 1'b0;
        clear_model(d);
    endtask

    // One transfer; returns at the negedge of the completing cycle with
    // PSEL/PENABLE still high so a following call runs back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data);
        int  n;
        bit  done;
        bit  err;
        int  idx;
        logic [31:0] exp_rd;
        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0;
        pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        n = 0; done = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (pready[d]) done = 1;
            else begin
                check("pslverr_low_wait", 32'(pslverr[d]), 0);
                @(posedge clk);
            end
        end
        if (!done) begin
            check("pready_timeout", 0, 1);
            return;
        end
        idx = int'(addr >> 2);
        err = (addr[1:0] != 2'b00) || (idx >= 16);
        check($sformatf("latency_d%0d", d), n, ws_of[d] + 1);
        check($sformatf("pslverr_%h", addr), 32'(pslverr[d]), 32'(err));
        exp_rd = (wr || err) ? 32'h0 : model[d][idx];
        check($sformatf("prdata_%h", addr), prdata[d], exp_rd);
        if (wr && !err) model[d][idx] = data;
    endtask

    logic [31:0] a;
    int          d;
    bit          w;

    initial begin
        ws_of[0] = 0; ws_of[1] = 3;
        for (int k = 0; k < 2; k++) begin
            preset[k] = 1'b1; psel[k] = 1'b0; penable[k] = 1'b0;
            paddr[k] = '0; pwrite[k] = 1'b0; pwdata[k] = '0;
            clear_model(k);
        end

        // Reset then idle on both instances.
        do_reset(0);
        do_reset(1);
        repeat (5) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check("rst_pready", 32'(pready[k]), 0);
                check("rst_pslverr", 32'(pslverr[k]), 0);
                check("rst_prdata", prdata[k], 0);
            end
        end

        // Basic write/read with no wait states.
        xfer(0, 1, 32'h08, 32'hDEADBEEF);
        xfer(0, 0, 32'h08, 32'h0);
        check("rd08_direct", prdata[0], 32'hDEADBEEF);
        xfer(0, 0, 32'h0C, 32'h0);
        idle(0, 1);

        // Three wait states.
        xfer(1, 1, 32'h04, 32'h12345678);
        xfer(1, 0, 32'h04, 32'h0);
        check("rd04_ws3", prdata[1], 32'h12345678);
        idle(1, 1);

        // Out-of-range write leaves every register untouched.
        xfer(0, 1, 32'h40, 32'hFFFFFFFF);
        check("err_wr_slverr", 32'(pslverr[0]), 1);
        for (int i = 0; i < 16; i++) xfer(0, 0, 32'(i * 4), 32'h0);
        xfer(0, 0, 32'h02, 32'h0);
        check("misaligned_slverr", 32'(pslverr[0]), 1);
        idle(0, 1);

        // Back-to-back writes then reads.
        xfer(0, 1, 32'h00, 32'hA0A0A0A0);
        xfer(0, 1, 32'h04, 32'hB1B1B1B1);
        xfer(0, 1, 32'h08, 32'hC2C2C2C2);
        xfer(0, 0, 32'h00, 32'h0);
        xfer(0, 0, 32'h04, 32'h0);
        xfer(0, 0, 32'h08, 32'h0);
        check("b2b_last", prdata[0], 32'hC2C2C2C2);
        idle(0, 1);

        // Master abort in the second access cycle of a wait-state write.
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0;
        pwrite[1] = 1'b1; paddr[1] = 32'h04; pwdata[1] = 32'h55AA55AA;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(negedge clk);
        check("abort_acc1_pready", 32'(pready[1]), 0);
        @(posedge clk); #1;
        psel[1] = 1'b0;
        @(negedge clk);
        check("abort_acc2_pready", 32'(pready[1]), 0);
        idle(1, 6);
        @(negedge clk);
        check("abort_idle_pready", 32'(pready[1]), 0);
        xfer(1, 0, 32'h04, 32'h0);
        xfer(1, 1, 32'h08, 32'h0BADF00D);
        xfer(1, 0, 32'h08, 32'h0);
        idle(1, 1);

        // Reset arriving on the completing cycle of a write.
        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b0;
        pwrite[0] = 1'b1; paddr[0] = 32'h10; pwdata[0] = 32'h77777777;
        @(posedge clk); #1;
        penable[0] = 1'b1; preset[0] = 1'b1;
        @(negedge clk);
        check("rstrdy_pready_before", 32'(pready[0]), 1);
        @(posedge clk); #1;
        preset[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
        clear_model(0);
        @(negedge clk);
        check("rstrdy_pready_after", 32'(pready[0]), 0);
        xfer(0, 0, 32'h10, 32'h0);
        xfer(0, 0, 32'h00, 32'h0);
        idle(0, 1);

        // Randomized traffic on both instances.
        for (int t = 0; t < 300; t++) begin
            d = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 17)) << 2;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            xfer(d, w, a, $urandom);
            if ($urandom_range(0, 1) == 0) idle(d, 1);
            else idle(d, 0);
        end
        idle(0, 1);
        idle(1, 1);

        // Final sweep of both register files.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) xfer(k, 0, 32'(i * 4), 32'h0);
            idle(k, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
